// File: rtl/avg_pool_unit.sv
// Purpose: streaming 2x2 average pool; accumulates 2**WIN_LOG2 signed samples and registers their floor mean.
// Latency: avg/avg_valid update one edge after the window's last sample is accepted.
// Backpressure: none; a sample is taken on every enabled cycle, and back-to-back windows run at full rate.
module avg_pool_unit #(
  parameter int DATA_W   = 32,
  parameter int WIN_LOG2 = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic signed [DATA_W-1:0] layer2,
  output logic signed [DATA_W-1:0] avg,
  output logic                     avg_valid
);

  // Adding WIN_LOG2 guard bits means a full window of extreme samples cannot overflow the sum.
  localparam int ACC_W = DATA_W + WIN_LOG2;
  localparam logic [WIN_LOG2-1:0] CNT_LAST = '1;
  localparam logic [WIN_LOG2-1:0] CNT_ONE  = WIN_LOG2'(1);

  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  sum;
  logic signed [ACC_W-1:0]  sample_ext;
  logic signed [ACC_W-1:0]  acc_next;
  logic signed [ACC_W-1:0]  sum_shift;
  logic [WIN_LOG2-1:0]      cnt;
  logic                     pending;

  // Sign-extend the incoming sample and form the running sum; division is a floor shift of the stored sum.
  always_comb begin
    sample_ext = {{WIN_LOG2{layer2[DATA_W-1]}}, layer2};
    acc_next   = acc + sample_ext;
    sum_shift  = sum >>> WIN_LOG2;
  end

  // Stage 1: accumulate enabled samples, hand the finished window sum to stage 2 and restart at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      cnt     <= '0;
      sum     <= '0;
      pending <= 1'b0;
    end else begin
      // Pending lasts one cycle unless another window completes on this very edge.
      pending <= 1'b0;
      if (enable) begin
        if (cnt == CNT_LAST) begin
          sum     <= acc_next;
          pending <= 1'b1;
          acc     <= '0;
          cnt     <= '0;
        end else begin
          acc <= acc_next;
          cnt <= cnt + CNT_ONE;
        end
      end
    end
  end

  // Stage 2: register the window mean and pulse avg_valid for the cycle it changes.
  always_ff @(posedge clk) begin
    if (rst) begin
      avg       <= '0;
      avg_valid <= 1'b0;
    end else begin
      avg_valid <= pending;
      if (pending) begin
        avg <= sum_shift[DATA_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_avg_pool_unit.sv
module tb_avg_pool_unit;

  logic               clk;
  logic               rst;
  logic               enable;
  logic signed [31:0] layer2;
  logic signed [31:0] avg;
  logic               avg_valid;

  int checks   = 0;
  int failures = 0;
  int pulses   = 0;

  avg_pool_unit #(.DATA_W(32), .WIN_LOG2(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .layer2    (layer2),
    .avg       (avg),
    .avg_valid (avg_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One rising edge with the given inputs; returns 1ns after the edge so outputs are settled.
  task automatic step(input logic r, input logic en, input logic [31:0] d);
    rst    = r;
    enable = en;
    layer2 = d;
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [31:0] d);
    step(1'b0, 1'b1, d);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 32'hDEADBEEF);
  endtask

  task automatic clear();
    step(1'b1, 1'b0, 32'h0);
  endtask

  // Clear, feed one window, then check the pulse timing, the result and that it holds.
  task automatic win(input string tag, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] c, input logic [31:0] d, input logic [31:0] exp);
    clear();
    feed(a);
    feed(b);
    feed(c);
    feed(d);
    chk({tag, "_novld_at_last"}, {31'b0, avg_valid}, 32'd0);
    idle();
    chk({tag, "_avg"}, avg, exp);
    chk({tag, "_vld"}, {31'b0, avg_valid}, 32'd1);
    idle();
    chk({tag, "_vld_drop"}, {31'b0, avg_valid}, 32'd0);
    chk({tag, "_avg_hold"}, avg, exp);
  endtask

  initial begin
    rst    = 1'b1;
    enable = 1'b0;
    layer2 = 32'h0;
    step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h12345678);
    chk("reset_avg", avg, 32'd0);
    chk("reset_vld", {31'b0, avg_valid}, 32'd0);

    // Basic window, then hold for ten idle cycles.
    win("basic", 32'd10, 32'd20, 32'd30, 32'd40, 32'd25);
    for (int i = 0; i < 9; i++) idle();
    chk("basic_hold10", avg, 32'd25);
    chk("basic_hold10_vld", {31'b0, avg_valid}, 32'd0);

    // Negative values and floor rounding.
    win("neg", -32'sd1, -32'sd2, -32'sd3, -32'sd4, -32'sd3);
    win("pos_floor", 32'd7, 32'd0, 32'd0, 32'd0, 32'd1);
    win("neg_floor", -32'sd7, 32'd0, 32'd0, 32'd0, -32'sd2);

    // Extremes exercise the guard bits.
    win("max", 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF);
    win("min", 32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000);
    win("mixed", 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h80000000, 32'h80000000, 32'hFFFFFFFF);

    // Gaps inside a window change nothing and produce no pulse.
    clear();
    feed(32'd4);
    feed(32'd8);
    for (int i = 0; i < 3; i++) begin
      idle();
      chk("gap_novld", {31'b0, avg_valid}, 32'd0);
    end
    feed(32'd12);
    feed(32'd16);
    idle();
    chk("gap_avg", avg, 32'd10);
    chk("gap_vld", {31'b0, avg_valid}, 32'd1);

    // Reset mid-window with enable high: partial sum and that sample are dropped, avg clears.
    feed(32'd100);
    feed(32'd200);
    step(1'b1, 1'b1, 32'd1000);
    chk("midrst_avg", avg, 32'd0);
    chk("midrst_vld", {31'b0, avg_valid}, 32'd0);
    feed(32'd1);
    feed(32'd2);
    feed(32'd3);
    feed(32'd6);
    idle();
    chk("midrst_after_avg", avg, 32'd3);
    chk("midrst_after_vld", {31'b0, avg_valid}, 32'd1);

    // Reset cancels a pending stage-2 update.
    clear();
    feed(32'd40);
    feed(32'd40);
    feed(32'd40);
    feed(32'd40);
    clear();
    chk("cancel_avg", avg, 32'd0);
    chk("cancel_vld", {31'b0, avg_valid}, 32'd0);
    idle();
    chk("cancel_vld_next", {31'b0, avg_valid}, 32'd0);

    // Back-to-back windows: pulses at edge 5 and edge 9 only.
    clear();
    pulses = 0;
    for (int k = 1; k <= 9; k++) begin
      if (k <= 8) feed(k);
      else idle();
      if (avg_valid) pulses++;
      if (k == 5) begin
        chk("b2b_e5_vld", {31'b0, avg_valid}, 32'd1);
        chk("b2b_e5_avg", avg, 32'd2);
      end else if (k == 9) begin
        chk("b2b_e9_vld", {31'b0, avg_valid}, 32'd1);
        chk("b2b_e9_avg", avg, 32'd6);
      end else begin
        chk("b2b_novld", {31'b0, avg_valid}, 32'd0);
      end
    end
    chk("b2b_pulses", pulses, 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/avg_pool_unit.md
Name: avg_pool_unit

Overview:
Streaming 2x2 average-pooling datapath used by the CNN core's pooling layer.
- Accepts one signed 32-bit sample per enabled clock.
- After every 4 accepted samples (one 2x2 window), registers their arithmetic mean on avg.
- The owning pooling layer pulses rst before each window, feeds 4 samples on consecutive enabled cycles, then reads avg a few cycles later.

Parameters:
DATA_W, 32, sample and result width (two's-complement signed).
WIN_LOG2, 2, log2 of samples per window (4 samples = 2x2 pool); divide is an arithmetic right shift by WIN_LOG2.

Ports:
clk  input  1  clock, all logic on rising edge.
rst  input  1  synchronous, active-high reset; also used as per-window clear.
enable  input  1  sample-valid; layer2 is accepted on a rising edge where enable=1 and rst=0.
layer2  input  DATA_W signed  input sample.
avg  output  DATA_W signed  registered window average.
avg_valid  output  1  one-cycle pulse coinciding with each avg update.

Behaviour:
- Reset, synchronous, active-high, on rst=1 at a rising edge:
  - accumulator = 0, sample count = 0, pending flag = 0, avg = 0, avg_valid = 0.
  - rst has priority over enable in the same cycle; that sample is discarded.
- Accumulator width is DATA_W+WIN_LOG2 (34 bits) signed. Each sample is sign-extended before adding, so the sum cannot overflow.
- Stage 1 (accumulate):
  - On an edge with enable=1, acc <= acc + sext(layer2) and count <= count+1.
  - When the sample being accepted is the 4th (count==3), the completed sum (acc + sample) is latched into a sum register, the pending flag is set, acc <= 0 and count <= 0.
  - The next enabled sample therefore starts a new window. No extra cycle is needed between windows.
- Stage 2 (divide):
  - On the edge after pending is set, avg <= sum >>> WIN_LOG2, truncated to DATA_W bits. This is an arithmetic shift, i.e. floor toward negative infinity.
  - avg_valid = 1 for exactly that cycle, and pending clears.
- Latency: 4th sample accepted at edge N -> avg/avg_valid updated at edge N+1. The owning layer reads at N+5 or later, so this latency is sufficient.
- enable=0: acc, count and avg all hold. Gaps between samples inside a window are allowed and do not change the result.
- avg holds its last value until the next window completes or rst is asserted.
- rst mid-window: the partial sum is discarded, avg = 0, and any pending stage-2 update is cancelled.
- A window completing at the same edge as stage 2 of the previous window: both happen. Stage 2 writes the old sum; the new sum becomes pending. Back-to-back windows of 4 consecutive enabled cycles each yield one avg_valid pulse per window.
- layer2 is ignored whenever enable=0. No X-propagation into acc from an unsampled input.
- No combinational path from any input to avg or avg_valid.

Test Plan:
- rst, then enable 4 cycles with 10,20,30,40 -> avg=25 and avg_valid=1 one edge after the 4th sample; avg still 25 ten cycles later.
- rst, then -1,-2,-3,-4 -> avg=-3 (floor of -2.5). Separately 7,0,0,0 -> avg=1; -7,0,0,0 -> avg=-2.
- Extremes: four of 0x7FFFFFFF -> avg=0x7FFFFFFF. Four of 0x80000000 -> avg=0x80000000. 0x7FFFFFFF,0x7FFFFFFF,0x80000000,0x80000000 -> avg=-1 (sum -2, floor of -0.5).
- Gapped enable: samples 4,8 then enable=0 for 3 cycles then 12,16 -> avg=10 one edge after 16; no avg_valid during the gap.
- rst after 2 of 4 samples (100,200), then 1,2,3,6 -> avg=3, avg=0 immediately after rst. rst asserted with enable=1 -> that sample ignored.
- 8 consecutive enabled samples 1..8 -> avg=2 (avg_valid at edge 5), then avg=6 (avg_valid at edge 9); exactly two pulses.
